ps2_receiver: RTL and testbench
===============================

PS2_RECEIVER -- requirements
Module: ps2_receiver

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries, power of two, 2..64.
REQ-002 Parameter FILT_LEN, default 4: clk cycles SCL must hold a new level before it is accepted, 1..16.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000: idle clk cycles after which a partial frame is discarded.
REQ-004 clk  in  1  system clock; all state is in this domain.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 SCL  in  1  PS/2 clock line, asynchronous to clk.
REQ-007 SDA  in  1  PS/2 data line, asynchronous to clk.
REQ-008 code_ready  in  1  consumer accepts the FIFO head.
REQ-009 code_data  out  10  FIFO head: {ext, brk, scan[7:0]}.
REQ-010 code_valid  out  1  FIFO non-empty.
REQ-011 fifo_count  out  clog2(DEPTH)+1  occupied entries.
REQ-012 frame_err  out  1  one-cycle pulse on a rejected frame.
REQ-013 overflow  out  1  sticky: an entry was dropped because the FIFO was full.
REQ-014 direction  out  5  one-hot movement code (macro-dependent).
REQ-015 rst_game  out  1  one-cycle pulse on ESC make (macro-dependent).

Function
REQ-016 SCL and SDA shall each pass a 2-flop synchroniser; the SCL filter shall update only after FILT_LEN consecutive equal samples.
REQ-017 A falling edge of the filtered SCL shall sample synchronised SDA into an 11-bit shift register, LSB first, with a 4-bit bit counter 0..10.
REQ-018 On the 11th bit: start=0, stop=1 and odd parity over data+parity are checked; any failure shall pulse frame_err the next cycle and push nothing.
REQ-019 A bit counter that is non-zero and has seen no filtered falling edge for TIMEOUT_CYCLES shall clear to 0 and pulse frame_err.
REQ-020 Prefix decode: 0xE0 sets pend_ext; 0xF0 sets pend_brk; neither prefix is pushed.
REQ-021 Any other valid byte shall push {pend_ext, pend_brk, byte} and clear both pend flags in the same cycle.
REQ-022 Push latency: code_valid rises 2 clk cycles after the clk edge that sampled the stop bit, when the FIFO was empty.
REQ-023 Pop occurs when code_valid and code_ready are both high at a clk edge; code_data shows the next entry on the following cycle.
REQ-024 Push into a full FIFO without a simultaneous pop shall drop the entry and set overflow.
REQ-025 Simultaneous push and pop shall hold fifo_count constant, including when full.
REQ-026 Pointers shall wrap modulo DEPTH; fifo_count shall never exceed DEPTH.
REQ-027 code_data shall be 0 when the FIFO is empty.

Reset
REQ-028 rst high shall immediately clear the FIFO, the pointers, fifo_count, the shift register, the bit counter, pend_ext, pend_brk, the timeout counter, frame_err, overflow and rst_game.
REQ-029 rst shall set direction to 5'b00001 (idle) and preset the SCL filter and synchroniser to 1.
REQ-030 A frame in progress when rst asserts shall be discarded; reception restarts on the first full frame after release.

Configuration
REQ-031 Macro PS2_DIR_DECODE_EN defined: each pushed non-break, non-extended scan updates direction: 0x1D->00010, 0x1C->00100, 0x1B->01000, 0x23->10000.
REQ-032 With PS2_DIR_DECODE_EN defined, all other scans leave direction unchanged, and scan 0x76 non-break pulses rst_game for one cycle.
REQ-033 Macro PS2_DIR_DECODE_EN undefined: direction is held at 5'b00001, rst_game is held at 0, and no decode logic is synthesised.
REQ-034 Direction update and rst_game shall occur on the push cycle, even when the entry is dropped by overflow.

Verification
REQ-035 Send frame 0x1D with valid parity, ready=1 -> code_data=0x01D, code_valid pulses 1 cycle, direction=00010 (macro on).
REQ-036 Send E0,75 -> one entry 0x275; send F0,1C -> one entry 0x11C, direction unchanged.
REQ-037 Send 0x23 with a parity bit flipped -> frame_err pulses once, fifo_count stays 0.
REQ-038 Send 6 bits then leave SCL idle for TIMEOUT_CYCLES -> frame_err pulses, next full 0x1B frame is received correctly.
REQ-039 DEPTH=8, ready=0, send 9 bytes -> fifo_count=8, overflow=1; drain -> first 8 bytes returned in order.
REQ-040 Assert rst during bit 5 -> all outputs at reset values within 1 cycle, next frame 0x76 pulses rst_game (macro on) / 0 (macro off).

Source files
------------

// File: rtl/ps2_code_if.sv
// ps2_code_if: scan-code stream from the PS/2 receiver FIFO to its consumer.
//   code_data  [9:0] FIFO head {ext, brk, scan[7:0]}, 0 when empty
//   code_valid       FIFO non-empty
//   code_ready       consumer accepts the head this cycle
//   master = receiver side, slave = consumer side
interface ps2_code_if;
    logic [9:0] code_data;
    logic       code_valid;
    logic       code_ready;

    modport master (output code_data, output code_valid, input code_ready);
    modport slave  (input code_data, input code_valid, output code_ready);
endinterface

// File: rtl/ps2_receiver.sv
// ps2_receiver: PS/2 keyboard frame receiver with prefix decode and a scan-code FIFO.
//   clk, rst          system clock, asynchronous active-high reset
//   SCL, SDA          PS/2 clock and data lines, asynchronous to clk
//   code (master)     code_data/code_valid/code_ready FIFO head stream
//   fifo_count        occupied FIFO entries
//   frame_err         one-cycle pulse on a rejected or timed-out frame
//   overflow          sticky, set when an entry is dropped on a full FIFO
//   direction         one-hot movement code, 5'b00001 when idle
//   rst_game          one-cycle pulse on ESC make
// Define PS2_DIR_DECODE_EN to build the direction / rst_game decoder;
// without it direction stays 5'b00001 and rst_game stays 0.
module ps2_receiver #(
    parameter int DEPTH          = 8,
    parameter int FILT_LEN       = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    SCL,
    input  logic                    SDA,
    ps2_code_if.master              code,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    frame_err,
    output logic                    overflow,
    output logic [4:0]              direction,
    output logic                    rst_game
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [4:0]    FILT_MAX = 5'(FILT_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} rx_state_t;

    logic scl_m, scl_s, sda_m, sda_s;
    logic scl_f;
    logic [4:0] filt_cnt;
    logic fall;

    // Synchronisers idle high so reset never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {scl_m, scl_s, sda_m, sda_s} <= 4'b1111;
        end else begin
            scl_m <= SCL;
            scl_s <= scl_m;
            sda_m <= SDA;
            sda_s <= sda_m;
        end
    end

    // Filtered SCL only changes after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_f    <= 1'b1;
            filt_cnt <= '0;
        end else if (scl_s == scl_f) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_MAX) begin
            scl_f    <= scl_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 5'd1;
        end
    end

    assign fall = scl_f && scl_s != scl_f && filt_cnt == FILT_MAX;

    rx_state_t state, state_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [10:0]   shreg, shreg_nxt;
    logic [TW-1:0] to_cnt, to_cnt_nxt;
    logic          timeout, check_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            to_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            to_cnt  <= to_cnt_nxt;
        end
    end

    // S_CHECK lasts one cycle: the frame is judged there, so a push lands
    // two edges after the edge that shifted in the stop bit.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        to_cnt_nxt  = '0;
        timeout     = 1'b0;
        check_en    = 1'b0;
        if (fall && state != S_CHECK)
            shreg_nxt = {sda_s, shreg[10:1]};
        case (state)
            S_IDLE: begin
                if (fall) begin
                    bit_cnt_nxt = 4'd1;
                    state_nxt   = S_RECV;
                end
            end
            S_RECV: begin
                if (fall) begin
                    bit_cnt_nxt = bit_cnt == 4'd10 ? 4'd0 : bit_cnt + 4'd1;
                    state_nxt   = bit_cnt == 4'd10 ? S_CHECK : S_RECV;
                end else if (to_cnt == TO_MAX) begin
                    bit_cnt_nxt = 4'd0;
                    state_nxt   = S_IDLE;
                    timeout     = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + TW'(1);
                end
            end
            S_CHECK: begin
                check_en  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    logic [7:0] scan;
    logic       frame_ok, is_e0, is_f0;
    logic       pend_ext, pend_brk;
    logic       push_q;
    logic [9:0] push_data;

    assign scan     = shreg[8:1];
    assign frame_ok = !shreg[0] && shreg[10] && ^shreg[9:1];
    assign is_e0    = scan == 8'hE0;
    assign is_f0    = scan == 8'hF0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_ext  <= 1'b0;
            pend_brk  <= 1'b0;
            push_q    <= 1'b0;
            push_data <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= timeout || (check_en && !frame_ok);
            push_q    <= check_en && frame_ok && !is_e0 && !is_f0;
            if (check_en && frame_ok) begin
                if (is_e0) begin
                    pend_ext <= 1'b1;
                end else if (is_f0) begin
                    pend_brk <= 1'b1;
                end else begin
                    push_data <= {pend_ext, pend_brk, scan};
                    pend_ext  <= 1'b0;
                    pend_brk  <= 1'b0;
                end
            end
        end
    end

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, pop, wr_en;

    assign full  = fifo_count == CW'(DEPTH);
    assign empty = fifo_count == '0;
    assign pop   = code.code_valid && code.code_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push_q && (!full || pop);

    assign code.code_valid = !empty;
    assign code.code_data  = empty ? '0 : mem[rd_ptr];

    // Storage is unreset: entries are never visible while fifo_count is 0.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(wr_en) - CW'(pop);
            if (push_q && full && !pop)
                overflow <= 1'b1;
        end
    end

`ifdef PS2_DIR_DECODE_EN
    logic plain;
    assign plain = push_q && !push_data[9] && !push_data[8];

    // Decoded on every push, including ones dropped by overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            direction <= 5'b00001;
            rst_game  <= 1'b0;
        end else begin
            rst_game <= push_q && !push_data[8] && push_data[7:0] == 8'h76;
            if (plain)
                direction <= push_data[7:0] == 8'h1D ? 5'b00010 :
                             push_data[7:0] == 8'h1C ? 5'b00100 :
                             push_data[7:0] == 8'h1B ? 5'b01000 :
                             push_data[7:0] == 8'h23 ? 5'b10000 : direction;
        end
    end
`else
    assign direction = 5'b00001;
    assign rst_game  = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver: randomized scoreboard bench for ps2_receiver.
module tb_ps2_receiver;
    localparam int DEPTH = 8;
    localparam int FILT  = 4;
    localparam int TO    = 300;
    localparam int P     = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic sda = 1'b1;
    logic [3:0] fifo_count;
    logic frame_err, overflow, rst_game;
    logic [4:0] direction;

    ps2_code_if bus ();

    ps2_receiver #(.DEPTH(DEPTH), .FILT_LEN(FILT), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .SCL(scl), .SDA(sda), .code(bus),
        .fifo_count(fifo_count), .frame_err(frame_err), .overflow(overflow),
        .direction(direction), .rst_game(rst_game)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [9:0] exp_q [$];
    int fe_seen = 0, fe_exp = 0, rg_seen = 0, rg_exp = 0;
    bit m_ext = 0, m_brk = 0, m_ovf = 0;
    logic [4:0] m_dir = 5'b00001;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    // Monitor: counts pulses and scores every accepted FIFO head.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_seen++;
            if (rst_game) rg_seen++;
            if (bus.code_valid && bus.code_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_pop: got %0h expected nothing", bus.code_data);
                end else begin
                    chk("code_data", bus.code_data, exp_q.pop_front());
                end
            end
        end
    end

    // Reference model of one accepted byte, at the level of the protocol rules.
    function automatic void model_byte(logic [7:0] b);
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, b});
            else m_ovf = 1;
`ifdef PS2_DIR_DECODE_EN
            if (!m_ext && !m_brk)
                case (b)
                    8'h1D: m_dir = 5'b00010;
                    8'h1C: m_dir = 5'b00100;
                    8'h1B: m_dir = 5'b01000;
                    8'h23: m_dir = 5'b10000;
                    default: ;
                endcase
            if (!m_brk && b == 8'h76) rg_exp++;
`endif
            m_ext = 0;
            m_brk = 0;
        end
    endfunction

    task automatic wait_cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(logic [10:0] f, int n);
        for (int i = 0; i < n; i++) begin
            sda = f[i];
            wait_cyc(P / 2);
            scl = 1'b0;
            wait_cyc(P);
            scl = 1'b1;
            wait_cyc(P / 2);
        end
    endtask

    task automatic send_byte(logic [7:0] b, bit bad);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        if (bad) fe_exp++;
        else model_byte(b);
        send_bits(f, 11);
        wait_cyc(12);
        chk("direction", direction, m_dir);
    endtask

    task automatic partial(int n);
        logic [10:0] f;
        f = 11'($urandom);
        fe_exp++;
        send_bits(f, n);
        wait_cyc(TO + 20);
    endtask

    task automatic checkpoint();
        chk("fifo_count", fifo_count, exp_q.size());
        chk("overflow", overflow, m_ovf);
        chk("frame_err_pulses", fe_seen, fe_exp);
        chk("rst_game_pulses", rg_seen, rg_exp);
        if (exp_q.size() == 0) chk("empty_data", bus.code_data, 0);
    endtask

    task automatic drain();
        int i;
        bus.code_ready = 1'b1;
        i = 0;
        while (exp_q.size() != 0 && i < 400) begin
            wait_cyc(1);
            i++;
        end
        wait_cyc(3);
        chk("drain_left", exp_q.size(), 0);
        checkpoint();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] picks [5];
        picks = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h76};
        bus.code_ready = 1'b1;
        wait_cyc(2);
        chk("rst_valid", bus.code_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_dir", direction, 5'b00001);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        wait_cyc(5);

        send_byte(8'h1D, 0);
        checkpoint();
        send_byte(8'hE0, 0);
        send_byte(8'h75, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h1C, 0);
        checkpoint();
        send_byte(8'h23, 1);
        checkpoint();
        partial(6);
        send_byte(8'h1B, 0);
        checkpoint();

        wait_cyc(1);
        bus.code_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 0);
        chk("full_count", fifo_count, DEPTH);
        checkpoint();
        drain();

        bus.code_ready = 1'b0;
        send_byte(8'h23, 0);
        send_byte(8'h44, 0);
        checkpoint();
        begin
            logic [10:0] f;
            f = {1'b1, ~^8'h5A, 8'h5A, 1'b0};
            send_bits(f, 4);
            sda = f[4];
            wait_cyc(P / 2);
            scl = 1'b0;
            wait_cyc(3);
            rst = 1'b1;
            #1;
            chk("rst_mid_valid", bus.code_valid, 0);
            chk("rst_mid_count", fifo_count, 0);
            chk("rst_mid_data", bus.code_data, 0);
            chk("rst_mid_ovf", overflow, 0);
            chk("rst_mid_dir", direction, 5'b00001);
            chk("rst_mid_ferr", frame_err, 0);
            chk("rst_mid_game", rst_game, 0);
            exp_q.delete();
            m_ext = 0;
            m_brk = 0;
            m_ovf = 0;
            m_dir = 5'b00001;
            scl = 1'b1;
            sda = 1'b1;
            wait_cyc(10);
            rst = 1'b0;
            bus.code_ready = 1'b1;
            wait_cyc(5);
        end
        send_byte(8'h76, 0);
        checkpoint();

        for (int k = 0; k < 40; k++) begin
            int r;
            bus.code_ready = $urandom_range(0, 3) != 0;
            wait_cyc(2);
            r = $urandom_range(0, 99);
            if (r < 15) send_byte(8'hE0, 0);
            else if (r < 27) send_byte(8'hF0, 0);
            else if (r < 35) send_byte(8'($urandom), 1);
            else if (r < 40) partial($urandom_range(1, 10));
            else if (r < 70) send_byte(picks[$urandom_range(0, 4)], 0);
            else send_byte(8'($urandom), 0);
            checkpoint();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
